// File: rtl/phase_ctrl.sv
// -----------------------------------------------------------------------------
// phase_ctrl
//
// Sequences each instruction of the 16-bit datapath around the calc ALU
// through five one-cycle phases:
//   P1 fetch, P2 register read, P3 execute, P4 memory, P5 write-back.
// It also holds the SZCV condition-code register and decides branches.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   exec          run request, sampled as a level (rising edge leaves HALT)
//   step          1 = return to IDLE after every instruction
//   instr         current IR contents, decoded combinationally
//   code          {S,Z,C,V} from the ALU, captured at the end of P3
//   phase         one-hot {P5,P4,P3,P2,P1}; 0 in IDLE and HALT
//   ir_we         load IR from memory (P1)
//   pc_inc        PC <= PC + 1 (P1)
//   pc_load       PC <= ALU result latch, i.e. branch target (P5)
//   ab_we         latch register-file operands A/B (P2)
//   dr_we         latch ALU result (P3)
//   mem_re        data-memory read, LW only (P4)
//   mem_we        data-memory write, ST only (P4)
//   rf_we         register-file write (P5)
//   out_we        output-port write, OUT only (P5)
//   szcv          condition-code register
//   branch_taken  branch decision, only meaningful in P5
//   halted        1 while in HALT
//   icount        retired-instruction count, wraps
// -----------------------------------------------------------------------------
module phase_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
  input  logic             step,
  input  logic [15:0]      instr,
  input  logic [3:0]       code,
  output logic [4:0]       phase,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ab_we,
  output logic             dr_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             rf_we,
  output logic             out_we,
  output logic [3:0]       szcv,
  output logic             branch_taken,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  // The P states are numbered 1..5 so the one-hot phase vector can be built
  // by comparing against (bit index + 1).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       szcv_reg, szcv_next;
  logic [CNT_W-1:0] icount_reg, icount_next;
  logic             exec_prev_reg;
  logic             exec_rise;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [1:0] op1;
  logic [3:0] op3;
  logic [4:0] top5;
  logic [2:0] cond;

  assign op1  = instr[15:14];
  assign op3  = instr[7:4];
  assign top5 = instr[15:11];
  assign cond = instr[10:8];

  // The low nibble carries register/immediate fields that only the datapath uses.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[3:0];

  logic is_alu_wb;
  logic is_out;
  logic is_hlt;
  logic is_lw;
  logic is_st;
  logic is_li;
  logic is_b;
  logic is_bcc;
  logic sets_flags;

  always_comb begin
    is_alu_wb  = 1'b0;
    is_out     = 1'b0;
    is_hlt     = 1'b0;
    is_lw      = 1'b0;
    is_st      = 1'b0;
    is_li      = 1'b0;
    is_b       = 1'b0;
    is_bcc     = 1'b0;
    sets_flags = 1'b0;

    case (op1)
      2'b11: begin
        case (op3)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
          4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: is_alu_wb = 1'b1;
          4'b1101: is_out = 1'b1;
          4'b1111: is_hlt = 1'b1;
          default: ;  // CMP (0101) only sets flags; the rest are NOPs
        endcase
        // Flag capture follows the ALU opcode range rather than the write-back
        // class: CMP sets flags, while IN (1100), OUT and HLT do not.
        sets_flags = (op3 <= 4'b1011);
      end
      2'b00: is_lw = 1'b1;
      2'b01: is_st = 1'b1;
      default: begin
        case (top5)
          5'b10000: is_li  = 1'b1;
          5'b10100: is_b   = 1'b1;
          5'b10111: is_bcc = 1'b1;
          default:  ;
        endcase
      end
    endcase
  end

  // Conditional branch test against the registered flags, so the decision
  // reflects the most recent flag-setting instruction, not the live ALU code.
  logic flag_s, flag_z, flag_v;
  logic cond_true;

  assign flag_s = szcv_reg[3];
  assign flag_z = szcv_reg[2];
  assign flag_v = szcv_reg[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = flag_z;                       // BE
      3'b001:  cond_true = flag_s ^ flag_v;              // BLT
      3'b010:  cond_true = flag_z | (flag_s ^ flag_v);   // BLE
      3'b011:  cond_true = ~flag_z;                      // BNE
      default: cond_true = 1'b0;
    endcase
  end

  // HALT is left only on a fresh request, so a run request still held high
  // from before the HLT does not restart the machine.
  assign exec_rise = exec & ~exec_prev_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      szcv_reg      <= 4'b0000;
      icount_reg    <= '0;
      exec_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      szcv_reg      <= szcv_next;
      icount_reg    <= icount_next;
      exec_prev_reg <= exec;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    szcv_next   = szcv_reg;
    icount_next = icount_reg;

    case (state_reg)
      S_IDLE: begin
        if (exec) state_next = S_P1;
      end
      S_P1: state_next = S_P2;
      S_P2: state_next = S_P3;
      S_P3: begin
        state_next = S_P4;
        if (sets_flags) szcv_next = code;
      end
      S_P4: state_next = S_P5;
      S_P5: begin
        // Every instruction retires here, HLT and NOP included.
        icount_next = icount_reg + CNT_W'(1);
        if (is_hlt)
          state_next = S_HALT;
        else if (step || !exec)
          state_next = S_IDLE;
        else
          state_next = S_P1;
      end
      S_HALT: begin
        if (exec_rise) state_next = S_P1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic taken;

  always_comb begin
    ir_we  = 1'b0;
    pc_inc = 1'b0;
    ab_we  = 1'b0;
    dr_we  = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    rf_we  = 1'b0;
    out_we = 1'b0;
    taken  = 1'b0;

    case (state_reg)
      S_P1: begin
        ir_we  = 1'b1;
        pc_inc = 1'b1;
      end
      S_P2: ab_we = 1'b1;
      S_P3: dr_we = 1'b1;
      S_P4: begin
        mem_re = is_lw;
        mem_we = is_st;
      end
      S_P5: begin
        rf_we  = is_alu_wb | is_lw | is_li;
        out_we = is_out;
        taken  = is_b | (is_bcc & cond_true);
      end
      default: ;
    endcase
  end

  assign branch_taken = taken;
  assign pc_load      = taken;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_phase
      assign phase[gi] = (state_reg == state_t'(3'(gi + 1)));
    end
  endgenerate

  assign halted = (state_reg == S_HALT);
  assign szcv   = szcv_reg;
  assign icount = icount_reg;

endmodule

// File: tb/tb_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_ctrl
//
// Directed scenarios followed by a randomized run. Every cycle the DUT outputs
// are compared with a behavioural model that tracks the position within the
// instruction (0 = idle, 1..5 = phase, 6 = halt), the flags and the retired
// count, using plain arithmetic over the instruction class table.
// The counter width is reduced so that wrap-around is reachable quickly.
// -----------------------------------------------------------------------------
module tb_phase_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          exec;
  logic          step;
  logic [15:0]   instr;
  logic [3:0]    code;
  logic [4:0]    phase;
  logic          ir_we, pc_inc, pc_load, ab_we, dr_we;
  logic          mem_re, mem_we, rf_we, out_we;
  logic [3:0]    szcv;
  logic          branch_taken;
  logic          halted;
  logic [CW-1:0] icount;

  phase_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .exec         (exec),
    .step         (step),
    .instr        (instr),
    .code         (code),
    .phase        (phase),
    .ir_we        (ir_we),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .ab_we        (ab_we),
    .dr_we        (dr_we),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .rf_we        (rf_we),
    .out_we       (out_we),
    .szcv         (szcv),
    .branch_taken (branch_taken),
    .halted       (halted),
    .icount       (icount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_pos   = 0;
  logic [3:0] m_flags = 4'b0000;
  int         m_count = 0;
  bit         m_prev  = 1'b0;

  // Values captured during run()
  logic r_mem_re, r_mem_we, r_rf_we, r_pc_load, r_taken;

  typedef enum int {K_ALU, K_CMP, K_OUT, K_HLT, K_NOP, K_LW, K_ST, K_LI, K_B, K_BC} kind_t;

  function automatic kind_t kind_of(input logic [15:0] w);
    int top2, op3, top5;
    top2 = int'(w[15:14]);
    op3  = int'(w[7:4]);
    top5 = int'(w[15:11]);
    if (top2 == 3) begin
      if (op3 == 5)  return K_CMP;
      if (op3 == 13) return K_OUT;
      if (op3 == 15) return K_HLT;
      if (op3 <= 4 || op3 == 6 || (op3 >= 8 && op3 <= 12)) return K_ALU;
      return K_NOP;
    end
    if (top2 == 0)  return K_LW;
    if (top2 == 1)  return K_ST;
    if (top5 == 16) return K_LI;
    if (top5 == 20) return K_B;
    if (top5 == 23) return K_BC;
    return K_NOP;
  endfunction

  function automatic bit flags_written(input logic [15:0] w);
    return (int'(w[15:14]) == 3) && (int'(w[7:4]) <= 11);
  endfunction

  function automatic bit model_taken(input logic [15:0] w, input logic [3:0] f);
    kind_t k;
    bit s, z, v, lt;
    k  = kind_of(w);
    s  = f[3];
    z  = f[2];
    v  = f[0];
    lt = (s != v);
    if (k == K_B) return 1'b1;
    if (k != K_BC) return 1'b0;
    case (int'(w[10:8]))
      0:       return z;
      1:       return lt;
      2:       return z || lt;
      3:       return !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    kind_t      k;
    logic [4:0] ph;
    bit         tk;
    k  = kind_of(instr);
    ph = (m_pos >= 1 && m_pos <= 5) ? 5'(1 << (m_pos - 1)) : 5'd0;
    tk = (m_pos == 5) && model_taken(instr, m_flags);
    check("phase",        phase,        ph);
    check("ir_we",        ir_we,        m_pos == 1);
    check("pc_inc",       pc_inc,       m_pos == 1);
    check("ab_we",        ab_we,        m_pos == 2);
    check("dr_we",        dr_we,        m_pos == 3);
    check("mem_re",       mem_re,       m_pos == 4 && k == K_LW);
    check("mem_we",       mem_we,       m_pos == 4 && k == K_ST);
    check("rf_we",        rf_we,        m_pos == 5 && (k == K_ALU || k == K_LW || k == K_LI));
    check("out_we",       out_we,       m_pos == 5 && k == K_OUT);
    check("branch_taken", branch_taken, tk);
    check("pc_load",      pc_load,      tk);
    check("szcv",         szcv,         m_flags);
    check("halted",       halted,       m_pos == 6);
    check("icount",       icount,       m_count);
  endtask

  // One clock: advance the model from the inputs present at the edge, then
  // compare every output 1 time unit after the edge.
  task automatic tick();
    int         np, nc;
    logic [3:0] nf;
    bit         nprev;
    np    = m_pos;
    nf    = m_flags;
    nc    = m_count;
    nprev = exec;
    if (rst) begin
      np    = 0;
      nf    = 4'b0000;
      nc    = 0;
      nprev = 1'b0;
    end else if (m_pos == 0) begin
      np = exec ? 1 : 0;
    end else if (m_pos >= 1 && m_pos <= 4) begin
      np = m_pos + 1;
      if (m_pos == 3 && flags_written(instr)) nf = code;
    end else if (m_pos == 5) begin
      nc = (m_count + 1) % (1 << CW);
      if (kind_of(instr) == K_HLT)   np = 6;
      else if (step || !exec)        np = 0;
      else                           np = 1;
    end else begin
      np = (exec && !m_prev) ? 1 : 6;
    end
    @(posedge clk);
    #1;
    m_pos   = np;
    m_flags = nf;
    m_count = nc;
    m_prev  = nprev;
    compare_all();
  endtask

  // Run one instruction from IDLE and return to IDLE.
  task automatic run(input logic [15:0] w, input logic [3:0] c);
    instr = w;
    code  = c;
    exec  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4) begin
        r_mem_re = mem_re;
        r_mem_we = mem_we;
      end
      if (i == 5) begin
        r_rf_we   = rf_we;
        r_pc_load = pc_load;
        r_taken   = branch_taken;
      end
    end
    exec = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] w;
    int          sel;

    // Reset with exec already requesting a run
    rst   = 1'b1;
    exec  = 1'b1;
    step  = 1'b0;
    instr = 16'hC000;
    code  = 4'b0000;
    tick();
    tick();
    check("reset_phase",  phase,  5'd0);
    check("reset_szcv",   szcv,   4'b0000);
    check("reset_icount", icount, 4'd0);
    check("reset_strobes", {ir_we, pc_inc, pc_load, ab_we, dr_we, mem_re, mem_we, rf_we, out_we}, 9'd0);
    $display("reset: phase=%b szcv=%b icount=%0d", phase, szcv, icount);

    // ADD: first P1 the cycle after rst falls
    rst = 1'b0;
    tick();
    check("add_p1", {phase, ir_we, pc_inc}, {5'b00001, 2'b11});
    tick();
    check("add_p2_ab_we", ab_we, 1'b1);
    code = 4'b0110;
    tick();
    check("add_p3_dr_we", dr_we, 1'b1);
    tick();
    check("add_p4_szcv", szcv, 4'b0110);
    tick();
    check("add_p5_rf_we", rf_we, 1'b1);
    exec = 1'b0;
    tick();
    check("add_icount", icount, 4'd1);
    $display("ADD: szcv=%b icount=%0d", szcv, icount);

    // CMP sets Z, BE taken
    run(16'hC050, 4'b0100);
    run(16'hB802, 4'b0000);
    check("be_taken", r_taken, 1'b1);
    check("be_pc_load", r_pc_load, 1'b1);
    $display("CMP Z=1, BE: taken=%b pc_load=%b", r_taken, r_pc_load);

    // CMP clears Z, BE not taken, flags unchanged by the branch
    run(16'hC050, 4'b0000);
    run(16'hB802, 4'b1111);
    check("be_not_taken", r_pc_load, 1'b0);
    check("be_szcv_kept", szcv, 4'b0000);
    $display("CMP Z=0, BE: pc_load=%b szcv=%b", r_pc_load, szcv);

    // LW then ST
    run(16'h0000, 4'b1010);
    check("lw_mem_re", r_mem_re, 1'b1);
    check("lw_rf_we",  r_rf_we,  1'b1);
    run(16'h4000, 4'b1010);
    check("st_mem_we", r_mem_we, 1'b1);
    check("st_mem_re", r_mem_re, 1'b0);
    check("st_rf_we",  r_rf_we,  1'b0);
    $display("LW/ST: st mem_we=%b rf_we=%b", r_mem_we, r_rf_we);

    // Single-step with exec held high
    step  = 1'b1;
    exec  = 1'b1;
    instr = 16'hC000;
    for (int i = 0; i < 6; i++) tick();
    check("step_idle", phase, 5'd0);
    tick();
    check("step_reenter", phase, 5'b00001);
    for (int i = 0; i < 5; i++) tick();
    $display("step: back in IDLE phase=%b", phase);

    // HLT, hold, resume on a rising edge of exec
    step  = 1'b0;
    instr = 16'hC0F0;
    for (int i = 0; i < 6; i++) tick();
    check("hlt_halted", halted, 1'b1);
    tick();
    check("hlt_held", {halted, phase}, {1'b1, 5'd0});
    exec = 1'b0;
    tick();
    exec = 1'b1;
    tick();
    check("hlt_resume", {halted, phase}, {1'b0, 5'b00001});
    instr = 16'hC000;
    for (int i = 0; i < 4; i++) tick();
    exec = 1'b0;
    tick();
    $display("HLT: resumed, now phase=%b icount=%0d", phase, icount);

    // Reset in P3 of ADD
    instr = 16'hC000;
    code  = 4'b1111;
    exec  = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_phase", phase, 5'd0);
    check("rst_mid_szcv",  szcv,  4'b0000);
    rst  = 1'b0;
    exec = 1'b0;
    tick();
    check("rst_mid_rf_we", rf_we, 1'b0);
    $display("reset in P3: phase=%b szcv=%b", phase, szcv);

    // Counter wrap with NOPs
    for (int i = 0; i < (1 << CW) - 1; i++) run(16'h8800, 4'b0000);
    check("icount_max", icount, 4'hF);
    run(16'h8800, 4'b0000);
    check("icount_wrap", icount, 4'h0);
    $display("wrap: icount=%0d", icount);

    // Randomized run against the model
    for (int n = 0; n < 800; n++) begin
      if (m_pos == 0 || m_pos >= 5) begin
        w   = 16'($urandom);
        sel = $urandom_range(0, 7);
        case (sel)
          0, 1, 2: w[15:14] = 2'b11;
          3:       w[15:11] = 5'b10111;
          4:       w[15:11] = 5'b10100;
          5:       w[15:11] = 5'b10000;
          default: ;
        endcase
        if (w[15:14] == 2'b11 && w[7:4] == 4'b0111) w[7:4] = 4'b0101;
        instr = w;
      end
      exec = ($urandom_range(0, 9) != 0);
      step = ($urandom_range(0, 5) == 0);
      code = 4'($urandom);
      rst  = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0;
    $display("random: done, last icount=%0d", icount);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
